// File: rtl/adpcm_step_adapter.sv
// IMA ADPCM decoder control: holds predictor and step index, hands the code to an
// external inverse quantizer and registers the reconstructed sample with a valid/ready output.
module adpcm_step_adapter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_valid,
  input  logic [15:0] init_sample,
  input  logic [6:0]  init_index,
  input  logic        code_valid,
  input  logic [3:0]  code,
  output logic        code_ready,
  output logic [3:0]  iq_code,
  output logic [15:0] iq_step_size,
  output logic [15:0] iq_prev_predicted,
  input  logic [15:0] iq_predicted,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready
);

  typedef enum logic {UNINIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [15:0]       pred_q;
  logic [6:0]        index_q, index_nxt, init_idx_clamped;
  logic signed [7:0] adj, idx_sum;
  logic              accept, consume;

  function automatic logic [15:0] step_rom(input logic [6:0] idx);
    logic [15:0] s;
    case (idx)
      7'd0:  s = 16'd7;     7'd1:  s = 16'd8;     7'd2:  s = 16'd9;     7'd3:  s = 16'd10;
      7'd4:  s = 16'd11;    7'd5:  s = 16'd12;    7'd6:  s = 16'd13;    7'd7:  s = 16'd14;
      7'd8:  s = 16'd16;    7'd9:  s = 16'd17;    7'd10: s = 16'd19;    7'd11: s = 16'd21;
      7'd12: s = 16'd23;    7'd13: s = 16'd25;    7'd14: s = 16'd28;    7'd15: s = 16'd31;
      7'd16: s = 16'd34;    7'd17: s = 16'd37;    7'd18: s = 16'd41;    7'd19: s = 16'd45;
      7'd20: s = 16'd50;    7'd21: s = 16'd55;    7'd22: s = 16'd60;    7'd23: s = 16'd66;
      7'd24: s = 16'd73;    7'd25: s = 16'd80;    7'd26: s = 16'd88;    7'd27: s = 16'd97;
      7'd28: s = 16'd107;   7'd29: s = 16'd118;   7'd30: s = 16'd130;   7'd31: s = 16'd143;
      7'd32: s = 16'd157;   7'd33: s = 16'd173;   7'd34: s = 16'd190;   7'd35: s = 16'd209;
      7'd36: s = 16'd230;   7'd37: s = 16'd253;   7'd38: s = 16'd279;   7'd39: s = 16'd307;
      7'd40: s = 16'd337;   7'd41: s = 16'd371;   7'd42: s = 16'd408;   7'd43: s = 16'd449;
      7'd44: s = 16'd494;   7'd45: s = 16'd544;   7'd46: s = 16'd598;   7'd47: s = 16'd658;
      7'd48: s = 16'd724;   7'd49: s = 16'd796;   7'd50: s = 16'd876;   7'd51: s = 16'd963;
      7'd52: s = 16'd1060;  7'd53: s = 16'd1166;  7'd54: s = 16'd1282;  7'd55: s = 16'd1411;
      7'd56: s = 16'd1552;  7'd57: s = 16'd1707;  7'd58: s = 16'd1878;  7'd59: s = 16'd2066;
      7'd60: s = 16'd2272;  7'd61: s = 16'd2499;  7'd62: s = 16'd2749;  7'd63: s = 16'd3024;
      7'd64: s = 16'd3327;  7'd65: s = 16'd3660;  7'd66: s = 16'd4026;  7'd67: s = 16'd4428;
      7'd68: s = 16'd4871;  7'd69: s = 16'd5358;  7'd70: s = 16'd5894;  7'd71: s = 16'd6484;
      7'd72: s = 16'd7132;  7'd73: s = 16'd7845;  7'd74: s = 16'd8630;  7'd75: s = 16'd9493;
      7'd76: s = 16'd10442; 7'd77: s = 16'd11487; 7'd78: s = 16'd12635; 7'd79: s = 16'd13899;
      7'd80: s = 16'd15289; 7'd81: s = 16'd16818; 7'd82: s = 16'd18500; 7'd83: s = 16'd20350;
      7'd84: s = 16'd22385; 7'd85: s = 16'd24623; 7'd86: s = 16'd27086; 7'd87: s = 16'd29794;
      7'd88: s = 16'd32767;
      default: s = 16'd32767; // unreachable: index_q is clamped to 88
    endcase
    return s;
  endfunction

  assign code_ready        = (state == RUN) && !init_valid && (!sample_valid || sample_ready);
  assign accept            = code_valid && code_ready;
  assign consume           = sample_valid && sample_ready;
  assign iq_code           = code;
  assign iq_step_size      = step_rom(index_q);
  assign iq_prev_predicted = pred_q;
  assign init_idx_clamped  = (init_index > 7'd88) ? 7'd88 : init_index;

  always_comb begin
    adj = 8'sd0;
    case (code[2:0])
      3'd4:    adj = 8'sd2;
      3'd5:    adj = 8'sd4;
      3'd6:    adj = 8'sd6;
      3'd7:    adj = 8'sd8;
      default: adj = -8'sd1;
    endcase
    idx_sum = $signed({1'b0, index_q}) + adj;
    if (idx_sum < 8'sd0)       index_nxt = 7'd0;
    else if (idx_sum > 8'sd88) index_nxt = 7'd88;
    else                       index_nxt = idx_sum[6:0];
  end

  always_comb begin
    state_nxt = state;
    if (init_valid) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNINIT;
    else        state <= state_nxt;
  end

  // init overrides any concurrent accept or consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q       <= '0;
      index_q      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (init_valid) begin
      pred_q       <= init_sample;
      index_q      <= init_idx_clamped;
      sample_valid <= 1'b0;
    end else if (accept) begin
      pred_q       <= iq_predicted;
      sample       <= iq_predicted;
      index_q      <= index_nxt;
      sample_valid <= 1'b1;
    end else if (consume) begin
      sample_valid <= 1'b0;
    end
  end

endmodule
